seg7_frame_feeder: RTL

//  Upstream stage of the 74HC595 display shifter. Holds a 4-digit hex value plus decimal points.

---
 rtl/seg7_pkg.sv | 39 +++
 rtl/seg7_frame_feeder_decode.sv | 14 +
 rtl/seg7_frame_feeder.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared types, constants and the hex to 7-segment table for the display feeder.
package seg7_pkg;

  localparam int NDIG_DEF = 4;

  // Segment pattern for a blanked digit (segments a..g all off)
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic {
    S_BLANK = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  // Active-high {g,f,e,d,c,b,a} pattern for one hex nibble
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      4'hF:    seg = 7'h71;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_frame_feeder_decode.sv
// Combinational digit decoder: nibble + blank flag + decimal point -> segment byte.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nib,
  input  logic       i_blank,
  input  logic       i_dp,
  output logic [7:0] o_segs
);

  // The decimal point is carried through even when the digit itself is blanked
  assign o_segs = {i_dp, (i_blank ? SEG_BLANK : hex_to_seg(i_nib))};

endmodule

// File: rtl/seg7_frame_feeder.sv
// Display feeder: double-buffered hex value, one digit handed to the shifter per request.
module seg7_frame_feeder
  import seg7_pkg::*;
#(
  parameter int NDIG     = NDIG_DEF,
  parameter bit BLANK_LZ = 1'b1
)(
  input  logic              SYSCLK,
  input  logic              RST,
  input  logic [4*NDIG-1:0] VALUE,
  input  logic [NDIG-1:0]   DPIN,
  input  logic              LOAD,
  output logic              PENDING,
  output logic              OVR,
  input  logic              NEXT,
  output logic [7:0]        SEGS,
  output logic [NDIG-1:0]   DIGSEL,
  output logic              SVALID,
  output logic              FRAME
);

  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IW-1:0]     r_idx;
  logic [IW-1:0]     w_idx_nxt;
  logic [4*NDIG-1:0] r_stg_val;
  logic [NDIG-1:0]   r_stg_dp;
  logic [4*NDIG-1:0] r_act_val;
  logic [NDIG-1:0]   r_act_dp;
  logic [4*NDIG-1:0] w_show_val;
  logic [NDIG-1:0]   w_show_dp;
  logic              r_pending;
  logic              r_ovr;
  logic [7:0]        r_segs;
  logic [NDIG-1:0]   r_digsel;
  logic              r_svalid;
  logic              r_frame;
  logic              w_accept;
  logic              w_wrap;
  logic              w_swap;
  logic [3:0]        w_nib;
  logic              w_dp;
  logic              w_nz;
  logic              w_blank;
  logic [7:0]        w_segs_dec;
  logic [7:0]        w_segs_out;

  // State register: leaves S_BLANK at the first swap
  always_ff @(posedge SYSCLK) begin
    if (RST) begin
      r_state <= S_BLANK;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, digit advance, swap decision and the digit about to be presented
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = NEXT & ~r_svalid;
    w_idx_nxt   = r_idx;
    w_wrap      = 1'b0;
    w_swap      = 1'b0;
    w_nib       = 4'h0;
    w_dp        = 1'b0;
    w_nz        = 1'b0;
    if (w_accept) begin
      w_wrap    = (r_idx == IDX_LAST);
      w_idx_nxt = w_wrap ? '0 : (r_idx + IW'(1));
      w_swap    = w_wrap & r_pending;
    end else begin
      w_wrap    = 1'b0;
    end
    if (w_swap) begin
      w_state_nxt = S_RUN;
      w_show_val  = r_stg_val;
      w_show_dp   = r_stg_dp;
    end else begin
      w_show_val  = r_act_val;
      w_show_dp   = r_act_dp;
    end
    // Digit i lives in the nibble counted from the MS end; w_nz tracks digits 0..idx
    for (int i = 0; i < NDIG; i++) begin
      if (IW'(i) == w_idx_nxt) begin
        w_nib = w_show_val[4*(NDIG-1-i) +: 4];
        w_dp  = w_show_dp[i];
      end else begin
        w_nib = w_nib;
      end
      if ((i <= int'(w_idx_nxt)) && (w_show_val[4*(NDIG-1-i) +: 4] != 4'h0)) begin
        w_nz = 1'b1;
      end else begin
        w_nz = w_nz;
      end
    end
    w_blank = BLANK_LZ && !w_nz && (w_idx_nxt != IDX_LAST);
    if (w_state_nxt == S_RUN) begin
      w_segs_out = w_segs_dec;
    end else begin
      w_segs_out = 8'h00;
    end
  end

  seg7_decode u_decode (
    .i_nib   (w_nib),
    .i_blank (w_blank),
    .i_dp    (w_dp),
    .o_segs  (w_segs_dec)
  );

  // Buffers, handshake flags and registered shifter outputs
  always_ff @(posedge SYSCLK) begin
    if (RST) begin
      r_idx     <= IDX_LAST;
      r_stg_val <= '0;
      r_stg_dp  <= '0;
      r_act_val <= '0;
      r_act_dp  <= '0;
      r_pending <= 1'b0;
      r_ovr     <= 1'b0;
      r_segs    <= 8'h00;
      r_digsel  <= '0;
      r_svalid  <= 1'b0;
      r_frame   <= 1'b0;
    end else begin
      r_svalid <= w_accept;
      r_frame  <= w_accept & w_wrap;
      if (w_accept) begin
        r_idx    <= w_idx_nxt;
        r_segs   <= w_segs_out;
        r_digsel <= NDIG'(1) << w_idx_nxt;
      end
      if (w_swap) begin
        r_act_val <= r_stg_val;
        r_act_dp  <= r_stg_dp;
      end
      // A LOAD on the swap edge refills staging without counting as an overrun
      if (LOAD) begin
        r_stg_val <= VALUE;
        r_stg_dp  <= DPIN;
        r_pending <= 1'b1;
        if (r_pending && !w_swap) begin
          r_ovr <= 1'b1;
        end
      end else if (w_swap) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign PENDING = r_pending;
  assign OVR     = r_ovr;
  assign SEGS    = r_segs;
  assign DIGSEL  = r_digsel;
  assign SVALID  = r_svalid;
  assign FRAME   = r_frame;

endmodule
